// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared ALU control codes, slice op codes and sequencer state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // B is inverted for subtract-style ops and NOR; the carry chain seeds from it.
  function automatic logic needs_binv(input logic [3:0] ctrl);
    return (ctrl == ALU_SUB) || (ctrl == ALU_SLT) || (ctrl == ALU_NOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_decode.sv
// ============================================================================
// alu_serial_decode : maps a 4-bit ALU control code onto 1-bit slice controls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_serial_decode
  import alu_pkg::*;
(
  input  logic [3:0] ctrl,
  output logic       ainv,
  output logic       binv,
  output logic [1:0] op,
  output logic       is_arith,
  output logic       is_slt,
  output logic       illegal
);

  always_comb begin
    ainv     = 1'b0;
    binv     = needs_binv(ctrl);
    op       = OP_AND;
    is_arith = 1'b0;
    is_slt   = 1'b0;
    illegal  = 1'b0;
    case (ctrl)
      ALU_AND: op = OP_AND;
      ALU_OR:  op = OP_OR;
      ALU_ADD: begin op = OP_ADD;  is_arith = 1'b1; end
      ALU_SUB: begin op = OP_ADD;  is_arith = 1'b1; end
      ALU_SLT: begin op = OP_LESS; is_slt   = 1'b1; end
      ALU_NOR: begin op = OP_AND;  ainv     = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
// alu_serial_ctrl : bit-serial sequencer driving one shared 1-bit ALU slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             sl_src1_o,
  output logic             sl_src2_o,
  output logic             sl_ainv_o,
  output logic             sl_binv_o,
  output logic             sl_cin_o,
  output logic [1:0]       sl_op_o,
  input  logic             sl_result_i,
  input  logic             sl_cout_i
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic             msb_cin;
  logic             msb_sum;

  logic             dec_ainv;
  logic             dec_binv;
  logic [1:0]       dec_op;
  logic             dec_is_arith;
  logic             dec_is_slt;
  logic             dec_illegal;

  logic             running;
  logic             fin_ovf;
  logic [WIDTH-1:0] fin_result;

  alu_serial_decode u_decode (
    .ctrl     (ctrl_q),
    .ainv     (dec_ainv),
    .binv     (dec_binv),
    .op       (dec_op),
    .is_arith (dec_is_arith),
    .is_slt   (dec_is_slt),
    .illegal  (dec_illegal)
  );

  assign running   = (state == ST_RUN);
  assign sl_src1_o = running & a_q[idx];
  assign sl_src2_o = running & b_q[idx];
  assign sl_ainv_o = running & dec_ainv;
  assign sl_binv_o = running & dec_binv;
  assign sl_cin_o  = running & carry;
  assign sl_op_o   = running ? dec_op : OP_AND;

  // SLT uses the true sign of A-B: raw MSB sum corrected by signed overflow.
  always_comb begin
    fin_ovf    = msb_cin ^ carry;
    fin_result = res;
    if (dec_illegal) begin
      fin_result = '0;
    end else if (dec_is_slt) begin
      fin_result = {{(WIDTH-1){1'b0}}, msb_sum ^ fin_ovf};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      res        <= '0;
      msb_cin    <= 1'b0;
      msb_sum    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            a_q    <= src1_i;
            b_q    <= src2_i;
            ctrl_q <= ctrl_i;
            idx    <= '0;
            carry  <= needs_binv(ctrl_i);
            busy_o <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          res[idx] <= sl_result_i;
          carry    <= sl_cout_i;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            msb_cin <= carry;
            msb_sum <= sl_result_i;
            state   <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          result_o   <= fin_result;
          zero_o     <= (fin_result == '0);
          cout_o     <= (dec_is_arith | dec_is_slt) & carry;
          overflow_o <= dec_is_arith & fin_ovf;
          done_o     <= 1'b1;
          busy_o     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// ============================================================================
// tb_alu_serial_ctrl : scoreboard bench for the serial ALU sequencer + slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   ctrl;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         ovf;
  logic         sl_src1, sl_src2, sl_ainv, sl_binv, sl_cin;
  logic [1:0]   sl_op;
  logic         sl_result, sl_cout;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  alu_serial_ctrl #(.WIDTH(W), .IDXW(5)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .src1_i      (src1),
    .src2_i      (src2),
    .ctrl_i      (ctrl),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .zero_o      (zero),
    .cout_o      (cout),
    .overflow_o  (ovf),
    .sl_src1_o   (sl_src1),
    .sl_src2_o   (sl_src2),
    .sl_ainv_o   (sl_ainv),
    .sl_binv_o   (sl_binv),
    .sl_cin_o    (sl_cin),
    .sl_op_o     (sl_op),
    .sl_result_i (sl_result),
    .sl_cout_i   (sl_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice; LESS presents the raw adder sum.
  logic sa, sb, ssum;
  always_comb begin
    sa        = sl_src1 ^ sl_ainv;
    sb        = sl_src2 ^ sl_binv;
    ssum      = sa ^ sb ^ sl_cin;
    sl_cout   = (sa & sb) | (sl_cin & (sa ^ sb));
    sl_result = 1'b0;
    case (sl_op)
      2'b00:   sl_result = sa & sb;
      2'b01:   sl_result = sa | sb;
      default: sl_result = ssum;
    endcase
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] c);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (c)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s   = {1'b0, a} + {1'b0, ~b} + 1;
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0111: begin
        s   = {1'b0, a} + {1'b0, ~b} + 1;
        e.c = s[W];
        e.r = ($signed(a) < $signed(b)) ? 1 : 0;
      end
      4'b1100: e.r = ~(a | b);
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: got r=%h z=%0b c=%0b v=%0b, none expected",
                 result, zero, cout, ovf);
      end else begin
        mon_e = sbq.pop_front();
        if ({result, zero, cout, ovf} !== mon_e) begin
          failures++;
          $display("FAIL result: got r=%h z=%0b c=%0b v=%0b, expected r=%h z=%0b c=%0b v=%0b",
                   result, zero, cout, ovf, mon_e.r, mon_e.z, mon_e.c, mon_e.v);
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c, input bit inject);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1; src1 = a; src2 = b; ctrl = c;
    sbq.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0; src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (inject && cyc == 10) begin
        start = 1'b1; src1 = ~a; src2 = 32'h0000_1234; ctrl = ALU_OR;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != W + 1) begin
      failures++;
      $display("FAIL latency: got %0d cycles, expected %0d", cyc, W + 1);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL busy_hold: busy dropped before done, expected continuous high");
    end
  endtask

  // start held high: second operation begins immediately on return to IDLE.
  task automatic run_b2b(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    int cyc;
    @(negedge clk);
    start = 1'b1; src1 = a; src2 = b; ctrl = c;
    sbq.push_back(model(a, b, c));
    sbq.push_back(model(a, b, c));
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != W + 2) begin
      failures++;
      $display("FAIL b2b_period: got %0d cycles between done pulses, expected %0d", cyc, W + 2);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [W+10:0] got;
    got = {busy, done, result, zero, cout, ovf, sl_src1, sl_src2, sl_ainv, sl_binv, sl_cin, sl_op};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL %s: got busy=%0b done=%0b r=%h z=%0b c=%0b v=%0b sl_op=%0b, expected all 0",
               name, busy, done, result, zero, cout, ovf, sl_op);
    end
  endtask

  logic [3:0] legal [6];
  logic [W-1:0] edge_vals [6];

  initial begin
    legal = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
    edge_vals = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h5};
    rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ctrl = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;

    run_op(32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0005, ALU_SUB, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, ALU_SLT, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0003, ALU_SLT, 1'b0);
    run_op(32'hF0F0_F0F0, 32'h0F0F_0F00, ALU_NOR, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 4'b1111, 1'b0);
    run_op(32'h1234_5678, 32'h0F0F_0F0F, ALU_ADD, 1'b1);
    run_b2b(32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD);

    // Abort mid-RUN at idx 12; nothing expected from the aborted op.
    @(negedge clk);
    start = 1'b1; src1 = 32'hAAAA_AAAA; src2 = 32'h5555_5555; ctrl = ALU_OR;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_run");
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd3, 32'd4, ALU_ADD, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
      run_op(a, b, ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 5)],
             1'b0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
